// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter.
// Index 0 is the load/store port, index 1 the fetch port.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]                   req_i;
    logic [1:0]                   we_i;
    logic [1:0][ADDR_W-1:0]       addr_i;
    logic [1:0][DATA_W-1:0]       wdata_i;
    logic [1:0][DATA_W/8-1:0]     be_i;
    logic [1:0]                   gnt_o;
    logic [1:0]                   rvalid_o;
    logic [1:0][DATA_W-1:0]       rdata_o;
    logic [1:0]                   err_o;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency BRAM between
// load/store (port 0) and fetch (port 1), with a tag pipeline for returns.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    mem_arbiter_if.slave        bus,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);
    logic               r_last_gnt;
    logic [MEM_LAT-1:0] r_tag_v;
    logic [MEM_LAT-1:0] r_tag_p;
    logic [MEM_LAT-1:0] r_tag_e;

    logic [1:0]         w_gnt;
    logic               w_accept;
    logic               w_sel;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_we;
    logic               w_aligned;
    logic               w_push;
    logic               w_out_v;
    logic               w_out_p;
    logic               w_out_e;

    // Round-robin grant: a lone requester wins, a tie goes to the other port
    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            unique case (bus.req_i)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_last_gnt ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign w_accept  = |w_gnt;
    assign w_sel     = w_gnt[1];
    assign w_addr    = bus.addr_i[w_sel];
    assign w_we      = bus.we_i[w_sel];
    assign w_aligned = (w_addr[1:0] == 2'b00);
    // Reads and every misaligned request expect a response
    assign w_push    = w_accept && (!w_we || !w_aligned);
    assign bus.gnt_o = w_gnt;

    // Drive the BRAM from the winner; misaligned requests never strobe it
    always_comb begin
        mem_en_o    = w_accept && w_aligned;
        mem_we_o    = w_accept && w_aligned && w_we;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (w_accept) begin
            mem_addr_o  = w_addr;
            mem_wdata_o = bus.wdata_i[w_sel];
            mem_be_o    = bus.be_i[w_sel];
        end
    end

    // Remember which port won the last accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
        end else if (w_accept) begin
            r_last_gnt <= w_sel;
        end
    end

    // Tag pipeline aligned with the BRAM read latency; shifts every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v <= '0;
            r_tag_p <= '0;
            r_tag_e <= '0;
        end else begin
            for (int i = MEM_LAT - 1; i > 0; i--) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_p[i] <= r_tag_p[i-1];
                r_tag_e[i] <= r_tag_e[i-1];
            end
            r_tag_v[0] <= w_push;
            r_tag_p[0] <= w_sel;
            r_tag_e[0] <= !w_aligned;
        end
    end

    assign w_out_v = r_tag_v[MEM_LAT-1];
    assign w_out_p = r_tag_p[MEM_LAT-1];
    assign w_out_e = r_tag_e[MEM_LAT-1];

    // Route the returning data to the port that issued it
    always_comb begin
        bus.rvalid_o = '0;
        bus.err_o    = '0;
        bus.rdata_o  = '0;
        if (w_out_v) begin
            bus.rvalid_o[w_out_p] = 1'b1;
            bus.err_o[w_out_p]    = w_out_e;
            bus.rdata_o[w_out_p]  = w_out_e ? '0 : mem_rdata_i;
        end
    end
endmodule
